// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter behind a valid/ready FIFO.
// Optional feature macro: UART_TX_PARITY_EN (parity bit and PARITY state).
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_ready,
    input  logic [1:0]                  parity_mode,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W  = PTR_W + 1;
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 push, pop, fifo_empty;
    logic                 baud_end, bit_last, stop_last;
    logic                 tx_nxt;

    // ---------------------------------------------------------------- FIFO
    assign fifo_empty = (fifo_count == '0);
    assign tx_ready   = (fifo_count != COUNT_W'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------- parity
`ifdef UART_TX_PARITY_EN
    logic par_en, par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en  <= 1'b0;
            par_bit <= 1'b0;
        end else if (pop) begin
            par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
            par_bit <= (^head) ^ (parity_mode == 2'd2);
        end
    end
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    // --------------------------------------------------------- serializer
    assign baud_end  = (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign bit_last  = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == BIT_W'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = START;
            START: if (baud_end) state_nxt = DATA;
            DATA: begin
                if (baud_end && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_end) state_nxt = STOP;
`endif
            STOP:  if (baud_end && stop_last) state_nxt = fifo_empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        tx_nxt = tx;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    tx_nxt = 1'b0;
                end
            end
            START: if (baud_end) tx_nxt = shift[0];
            DATA: begin
                if (baud_end) begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt = par_en ? par_bit : 1'b1;
`else
                        tx_nxt = 1'b1;
`endif
                    end else begin
                        tx_nxt = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_end) tx_nxt = 1'b1;
`endif
            STOP: begin
                if (baud_end && stop_last) begin
                    pop    = !fifo_empty;
                    tx_nxt = fifo_empty;
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    // bit_cnt is reused as the stop-bit counter; it clears on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            tx      <= tx_nxt;
            // Registered from next state so busy rises with the start bit, not the push.
            tx_busy <= (state_nxt != IDLE);
            if (pop || baud_end || state == IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (state != state_nxt)
                bit_cnt <= '0;
            else if (baud_end)
                bit_cnt <= bit_cnt + 1'b1;
            if (pop)
                shift <= head;
            else if (state == DATA && baud_end)
                shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: 8N1 instance (a) and 7-bit/2-stop instance (b),
// both at BAUD_DIV = 10.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] parity_mode;

    logic       valid_a, ready_a, tx_a, busy_a;
    logic [7:0] data_a;
    logic [2:0] count_a;

    logic       valid_b, ready_b, tx_b, busy_b;
    logic [6:0] data_b;
    logic [2:0] count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_a), .tx_data(data_a), .tx_ready(ready_a),
        .parity_mode(parity_mode), .tx(tx_a), .tx_busy(busy_a), .fifo_count(count_a)
    );

    uart_tx_fifo #(
        .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_b), .tx_data(data_b), .tx_ready(ready_b),
        .parity_mode(parity_mode), .tx(tx_b), .tx_busy(busy_b), .fifo_count(count_b)
    );

    // Expected line level k cycles after the start-bit edge (8-bit frame, optional parity).
    function automatic logic exp_a(input logic [7:0] d, input int k, input logic par_on,
                                   input logic par_val);
        logic [7:0] s;
        if (k < 10) return 1'b0;
        if (k < 90) begin
            s = d >> ((k - 10) / 10);
            return s[0];
        end
        if (par_on && k < 100) return par_val;
        return 1'b1;
    endfunction

    function automatic logic exp_b(input logic [6:0] d, input int k);
        logic [6:0] s;
        if (k < 10) return 1'b0;
        if (k < 80) begin
            s = d >> ((k - 10) / 10);
            return s[0];
        end
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx_a got=%b exp=1", tx_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count_a got=%0d exp=0", count_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got=%b exp=1", ready_a); end
        checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b got=%b exp=1", tx_b); end
        checks++; if (count_b !== 3'd0) begin errors++; $display("FAIL reset_count_b got=%0d exp=0", count_b); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_frame_8n1();
        logic [7:0] d;
        d = 8'hA5;
        data_a = d; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL 8n1_count_push got=%0d exp=1", count_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL 8n1_busy_push got=%b exp=0", busy_a); end
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL 8n1_tx_push got=%b exp=1", tx_a); end
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            checks++;
            if (tx_a !== exp_a(d, k, 1'b0, 1'b0)) begin
                errors++; $display("FAIL 8n1_tx cycle=%0d got=%b exp=%b", k + 1, tx_a, exp_a(d, k, 1'b0, 1'b0));
            end
            checks++;
            if (busy_a !== 1'b1) begin errors++; $display("FAIL 8n1_busy cycle=%0d got=%b exp=1", k + 1, busy_a); end
        end
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL 8n1_busy_end got=%b exp=0", busy_a); end
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL 8n1_tx_end got=%b exp=1", tx_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL 8n1_count_end got=%0d exp=0", count_a); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        logic [1:0] modes [3];
        logic       pbits [3];
        d = 8'hA5;
        modes = '{2'd1, 2'd2, 2'd2};
        pbits = '{1'b0, 1'b1, 1'b1};
        for (int r = 0; r < 3; r++) begin
            parity_mode = modes[r];
            data_a = d; valid_a = 1'b1;
            @(posedge clk); #1;
            valid_a = 1'b0;
            for (int k = 0; k < 110; k++) begin
                @(posedge clk); #1;
                if (r == 2 && k == 30) parity_mode = 2'd1;
                checks++;
                if (tx_a !== exp_a(d, k, 1'b1, pbits[r])) begin
                    errors++;
                    $display("FAIL parity run=%0d cycle=%0d got=%b exp=%b", r, k + 1, tx_a,
                             exp_a(d, k, 1'b1, pbits[r]));
                end
            end
            checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL parity_busy_110 run=%0d got=%b exp=1", r, busy_a); end
            @(posedge clk); #1;
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL parity_busy_end run=%0d got=%b exp=0", r, busy_a); end
        end
        parity_mode = 2'd0;
    endtask
`else
    task automatic test_parity();
        logic [7:0] d;
        d = 8'hA5;
        parity_mode = 2'd1;
        data_a = d; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            checks++;
            if (tx_a !== exp_a(d, k, 1'b0, 1'b0)) begin
                errors++; $display("FAIL noparity_tx cycle=%0d got=%b exp=%b", k + 1, tx_a, exp_a(d, k, 1'b0, 1'b0));
            end
        end
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL noparity_busy_end got=%b exp=0", busy_a); end
        parity_mode = 2'd0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] words [6];
        int         acc_edge [6];
        int         exp_edge [6];
        int         idx;
        int         f;
        int         k;
        logic       acc;
        logic [2:0] cnt_e1, cnt_e4;
        logic       rdy_e4;
        words    = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3};
        exp_edge = '{0, 1, 2, 3, 4, 102};
        acc_edge = '{-1, -1, -1, -1, -1, -1};
        idx = 0; cnt_e1 = '0; cnt_e4 = '0; rdy_e4 = 1'b1;
        valid_a = 1'b1; data_a = words[0];
        for (int e = 0; e <= 601; e++) begin
            acc = valid_a && ready_a;
            @(posedge clk); #1;
            if (acc) begin
                acc_edge[idx] = e;
                idx++;
                if (idx < 6) data_a = words[idx];
                else valid_a = 1'b0;
            end
            if (e == 1) cnt_e1 = count_a;
            if (e == 4) begin cnt_e4 = count_a; rdy_e4 = ready_a; end
            if (e >= 1 && e <= 600) begin
                f = (e - 1) / 100;
                k = (e - 1) % 100;
                checks++;
                if (tx_a !== exp_a(words[f], k, 1'b0, 1'b0)) begin
                    errors++; $display("FAIL b2b_tx edge=%0d got=%b exp=%b", e, tx_a, exp_a(words[f], k, 1'b0, 1'b0));
                end
            end
        end
        valid_a = 1'b0;
        checks++; if (idx !== 6) begin errors++; $display("FAIL b2b_accepted got=%0d exp=6", idx); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc_edge[i] !== exp_edge[i]) begin
                errors++; $display("FAIL b2b_accept_edge word=%0d got=%0d exp=%0d", i, acc_edge[i], exp_edge[i]);
            end
        end
        checks++; if (cnt_e1 !== 3'd1) begin errors++; $display("FAIL b2b_count_e1 got=%0d exp=1", cnt_e1); end
        checks++; if (cnt_e4 !== 3'd4) begin errors++; $display("FAIL b2b_count_full got=%0d exp=4", cnt_e4); end
        checks++; if (rdy_e4 !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got=%b exp=0", rdy_e4); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL b2b_count_end got=%0d exp=0", count_a); end
    endtask

    task automatic test_stop2_7bit();
        logic [6:0] words [2];
        words = '{7'h7F, 7'h2A};
        for (int w = 0; w < 2; w++) begin
            data_b = words[w]; valid_b = 1'b1;
            @(posedge clk); #1;
            valid_b = 1'b0;
            checks++; if (count_b !== 3'd1) begin errors++; $display("FAIL s2_count_push word=%0d got=%0d exp=1", w, count_b); end
            for (int k = 0; k < 100; k++) begin
                @(posedge clk); #1;
                checks++;
                if (tx_b !== exp_b(words[w], k)) begin
                    errors++; $display("FAIL s2_tx word=%0d cycle=%0d got=%b exp=%b", w, k + 1, tx_b, exp_b(words[w], k));
                end
            end
            checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL s2_busy_100 word=%0d got=%b exp=1", w, busy_b); end
            @(posedge clk); #1;
            checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL s2_busy_end word=%0d got=%b exp=0", w, busy_b); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] words [3];
        words = '{8'h00, 8'h55, 8'hAA};
        valid_a = 1'b1; data_a = words[0];
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            if (e < 2) data_a = words[e + 1];
            else valid_a = 1'b0;
        end
        checks++; if (count_a !== 3'd2) begin errors++; $display("FAIL rst_mid_queued got=%0d exp=2", count_a); end
        // edges 3..45 complete; edge 45 is inside data bit 3 of word 0 (low)
        for (int e = 3; e <= 45; e++) @(posedge clk);
        #1;
        checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL rst_mid_bit3 got=%b exp=0", tx_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got=%b exp=1", tx_a); end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", count_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy_a); end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready_a); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            checks++;
            if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_post_tx cycle=%0d got=%b exp=1", k + 1, tx_a); end
            checks++;
            if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_post_busy cycle=%0d got=%b exp=0", k + 1, busy_a); end
        end
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL rst_post_count got=%0d exp=0", count_a); end
    endtask

    initial begin
        rst_n = 1'b1;
        parity_mode = 2'd0;
        valid_a = 1'b0; data_a = '0;
        valid_b = 1'b0; data_b = '0;
        test_reset();
        test_frame_8n1();
        test_parity();
        test_back_to_back();
        test_stop2_7bit();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
